// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle Hack ALU sequencer sharing a single 16-bit inverter.
// Optional macro ALU_SEQ_SKIP_EN skips the SX/SY/SN steps that would not change data.

module not_16bit_chip (
  input  logic [15:0] in,
  output logic [15:0] out
);
  assign out = ~in;
endmodule

module alu_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

`ifdef ALU_SEQ_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SX   = 3'd1,
    S_SY   = 3'd2,
    S_SF   = 3'd3,
    S_SN   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, acc_q, acc_d, out_q, out_d;
  logic [5:0]       cr_q, cr_d;
  logic             zr_q, zr_d, ng_q, ng_d;
  logic [WIDTH-1:0] not_in_s, not_out_s, fres_s, nres_s;

  function automatic state_t after_sx(input logic [5:0] c);
    if (SKIP_EN && (c[3:2] == 2'b00)) return S_SF;
    else return S_SY;
  endfunction

  function automatic state_t after_idle(input logic [5:0] c);
    if (SKIP_EN && (c[5:4] == 2'b00)) return after_sx(c);
    else return S_SX;
  endfunction

  function automatic state_t after_sf(input logic [5:0] c);
    if (SKIP_EN && !c[0]) return S_DONE;
    else return S_SN;
  endfunction

  not_16bit_chip u_not (
    .in  (not_in_s),
    .out (not_out_s)
  );

  // Shared inverter input: zero-forced operand in SX/SY, accumulator in SN.
  always_comb begin
    not_in_s = {WIDTH{1'b0}};
    case (state_q)
      S_SX:    not_in_s = cr_q[5] ? {WIDTH{1'b0}} : xr_q;
      S_SY:    not_in_s = cr_q[3] ? {WIDTH{1'b0}} : yr_q;
      S_SN:    not_in_s = acc_q;
      default: not_in_s = {WIDTH{1'b0}};
    endcase
  end

  assign fres_s = cr_q[1] ? (xr_q + yr_q) : (xr_q & yr_q);
  assign nres_s = cr_q[0] ? not_out_s : acc_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    cr_d    = cr_q;
    acc_d   = acc_q;
    out_d   = out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          xr_d    = x;
          yr_d    = y;
          cr_d    = ctrl;
          state_d = after_idle(ctrl);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SX: begin
        xr_d    = cr_q[4] ? not_out_s : not_in_s;
        state_d = after_sx(cr_q);
      end
      S_SY: begin
        yr_d    = cr_q[2] ? not_out_s : not_in_s;
        state_d = S_SF;
      end
      S_SF: begin
        acc_d   = fres_s;
        state_d = after_sf(cr_q);
        // With no=0 in the skipping build the sum is already the final result.
        if (after_sf(cr_q) == S_DONE) begin
          out_d = fres_s;
          zr_d  = (fres_s == {WIDTH{1'b0}});
          ng_d  = fres_s[WIDTH-1];
        end else begin
          out_d = out_q;
        end
      end
      S_SN: begin
        out_d   = nres_s;
        zr_d    = (nres_s == {WIDTH{1'b0}});
        ng_d    = nres_s[WIDTH-1];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      xr_q    <= {WIDTH{1'b0}};
      yr_q    <= {WIDTH{1'b0}};
      cr_q    <= 6'd0;
      acc_q   <= {WIDTH{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      cr_q    <= cr_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed test-plan cases plus random operations
// checked against a direct Hack ALU formula.
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x = 16'h0000;
  logic [15:0] y = 16'h0000;
  logic [5:0]  ctrl = 6'd0;
  logic        in_ready, out_valid, zr, ng, busy;
  logic [15:0] out;

  int passed = 0;
  int total  = 0;

  alu_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0000 : a;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : b;
    if (c[2]) yy = ~yy;
    r = c[1] ? 16'(xx + yy) : (xx & yy);
    if (c[0]) r = ~r;
    return r;
  endfunction

  function automatic int exp_lat(input logic [5:0] c);
    int full, skip;
    full = 4;
    skip = 1 + ((c[5] | c[4]) ? 1 : 0) + ((c[3] | c[2]) ? 1 : 0) + (c[0] ? 1 : 0);
`ifdef ALU_SEQ_SKIP_EN
    return skip;
`else
    return full + 0 * skip;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present an operation at #1 after an edge, let it be accepted, then scramble the inputs.
  task automatic launch(input logic [15:0] ax, input logic [15:0] ay, input logic [5:0] ac);
    check("pre_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; x = ax; y = ay; ctrl = ac;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input logic [5:0] ac, input logic [15:0] eo, input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat(ac)));
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out"}, 32'(out), 32'(eo));
    check({tag, "_zr"}, 32'(zr), 32'(eo == 16'h0000));
    check({tag, "_ng"}, 32'(ng), 32'(eo[15]));
  endtask

  task automatic retire(input int hold, input logic [15:0] eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out", 32'(out), 32'(eo));
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_valid", 32'(out_valid), 32'd0);
    check("ret_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] ax, input logic [15:0] ay, input logic [5:0] ac,
                        input logic [15:0] eo, input string tag, input int hold);
    launch(ax, ay, ac);
    wait_result(ac, eo, tag);
    retire(hold, eo);
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic [5:0]  rc;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_zr", 32'(zr), 32'd0);
    check("rst_ng", 32'(ng), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd5, 16'd3, 6'b000010, 16'h0008, "add", 0);
    run_op(16'd5, 16'd3, 6'b010011, 16'h0002, "x_minus_y", 1);
    run_op(16'd5, 16'd3, 6'b000111, 16'hFFFE, "y_minus_x", 0);
    run_op(16'd5, 16'd3, 6'b101010, 16'h0000, "zero", 0);
    run_op(16'd5, 16'd3, 6'b111010, 16'hFFFF, "minus1", 0);
    run_op(16'h7FFF, 16'h0001, 6'b000010, 16'h8000, "ovf", 0);
    run_op(16'hFFFF, 16'h0001, 6'b000010, 16'h0000, "carry", 0);
    run_op(16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030, "and", 0);

    // Backpressure with a second operation offered while DONE is held.
    launch(16'd5, 16'd3, 6'b000010);
    wait_result(6'b000010, 16'h0008, "bp_a");
    in_valid = 1'b1; x = 16'd9; y = 16'd4; ctrl = 6'b010011;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out", 32'(out), 32'h0008);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_ret_valid", 32'(out_valid), 32'd0);
    check("bp_not_taken", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; x = 16'($urandom); ctrl = 6'($urandom);
    check("bp_taken", 32'(busy), 32'd1);
    wait_result(6'b010011, 16'h0005, "bp_b");
    retire(0, 16'h0005);

    // Asynchronous reset while the operation sits in SF (non-skipping build timing).
    launch(16'h1234, 16'h0001, 6'b000011);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    run_op(16'd5, 16'd3, 6'b010011, 16'h0002, "post_rst", 0);

    for (int k = 0; k < 24; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom);
      if (k % 6 == 0) rx = 16'h0000;
      run_op(rx, ry, rc, hack_alu(rx, ry, rc), "rand", int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
